imem_fetch_ctrl: RTL

- Instruction-fetch sequencer for the combinational instruction ROM (byte-addressed, 32-bit word-aligned reads, 64-bit address).
- Owns the PC and drives the ROM address.
- Buffers fetched {pc, instruction} pairs in a small FIFO and delivers them to decode over a valid/ready handshake.
- Handles branch redirects (flush and retarget) and flags misaligned or out-of-range PCs before they reach the ROM.

---
 rtl/imem_fetch_ctrl_if.sv | 46 ++++
 rtl/imem_fetch_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl_if
//  Description : Fetch-side bus bundle: instruction ROM, decode handshake,
//                branch redirect and fault reporting.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fault;
    logic [63:0] fault_pc;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect_valid,
        input  redirect_pc,
        output fault,
        output fault_pc
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect_valid,
        output redirect_pc,
        input  fault,
        input  fault_pc
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : PC sequencer for a combinational instruction ROM with a small
//                {pc, instr} FIFO toward decode, redirect flush and bad-PC fault.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int          MEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          QDEPTH    = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    imem_fetch_ctrl_if.master   bus
);

    localparam int          c_PTR_W     = $clog2(QDEPTH);
    localparam int          c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(QDEPTH);
    localparam logic [63:0] c_LAST_WORD = 64'(MEM_BYTES - 4);

    localparam logic [0:0]  c_S_RUN     = 1'b0;
    localparam logic [0:0]  c_S_FAULT   = 1'b1;

    logic [0:0]         r_state;
    logic [63:0]        r_pc;
    logic [63:0]        r_fault_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [63:0]        r_mem_pc    [QDEPTH];
    logic [31:0]        r_mem_instr [QDEPTH];

    logic w_pc_ok;
    logic w_empty;
    logic w_out_valid;
    logic w_deq;
    logic w_push;

    // Range check is a plain 64-bit unsigned compare so huge targets never alias.
    assign w_pc_ok     = (r_pc[1:0] == 2'b00) && (r_pc <= c_LAST_WORD);
    assign w_empty     = (r_count == '0);
    assign w_out_valid = !w_empty && !bus.redirect_valid;
    assign w_deq       = w_out_valid && bus.out_ready;
    assign w_push      = (r_state == c_S_RUN) && !bus.redirect_valid && w_pc_ok
                         && ((r_count < c_DEPTH) || w_deq);

    assign bus.imem_addr = ((r_state == c_S_RUN) && w_pc_ok) ? r_pc : 64'h0;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pc    = w_empty ? 64'h0 : r_mem_pc[r_rd_ptr];
    assign bus.out_instr = w_empty ? 32'h0 : r_mem_instr[r_rd_ptr];
    assign bus.fault     = (r_state == c_S_FAULT) && w_empty;
    assign bus.fault_pc  = r_fault_pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_S_RUN;
            r_pc       <= RESET_PC;
            r_fault_pc <= 64'h0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (bus.redirect_valid) begin
            r_state  <= c_S_RUN;
            r_pc     <= bus.redirect_pc;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_deq);
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_pc     <= r_pc + 64'd4;
            end
            if ((r_state == c_S_RUN) && !w_pc_ok) begin
                r_state    <= c_S_FAULT;
                r_fault_pc <= r_pc;
            end
        end
    end

    // Storage needs no reset: entries are only visible while the count covers them.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_pc;
            r_mem_instr[r_wr_ptr] <= bus.imem_instr;
        end
    end

endmodule
`default_nettype wire
